fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controller that sequences the instruction_fetch stage. It drives the fetch stage's clock-enable, PC-change strobe and redirect PC. It arbitrates redirect requests from the ID stage (jumps) and the EX stage (resolved branches) against hazard stalls and halt, and generates the pipeline flush strobes for the IF/ID and ID/EX registers. It sits between the hazard/branch logic and the fetch stage, on the fetch stage's clock and reset.

Parameters:
PC_WIDTH, 32, width of all PC/target buses
RESET_PC, 0, PC value presented with the first change_pc pulse after boot
BOOT_DELAY, 2, cycles held in BOOT after reset release before fetch is enabled (1..15)
CNT_WIDTH, 16, width of performance counters (optional feature only)

Ports:
fs_clk  in  1  clock, rising edge
fs_rst  in  1  asynchronous, active-low reset
fs_i_stall  in  1  hazard stall request (load-use), level
fs_i_id_redirect  in  1  jump taken in ID, single-cycle pulse
fs_i_id_target  in  PC_WIDTH  jump target, valid with fs_i_id_redirect
fs_i_ex_redirect  in  1  branch mispredict/taken in EX, single-cycle pulse
fs_i_ex_target  in  PC_WIDTH  branch target, valid with fs_i_ex_redirect
fs_i_halt  in  1  halt request (e.g. break/syscall), level
fs_o_ce  out  1  to fetch f_i_ce
fs_o_change_pc  out  1  to fetch f_i_change_pc
fs_o_pc  out  PC_WIDTH  to fetch f_i_pc
fs_o_flush_ifid  out  1  clear IF/ID register
fs_o_flush_idex  out  1  clear ID/EX register
fs_o_state  out  2  current FSM state (debug)

Behaviour:
- Reset (fs_rst=0, async): state=BOOT, boot counter=0, all outputs 0, fs_o_pc=RESET_PC.
- All outputs are registered; a response appears on the clock edge after the input is sampled (1-cycle latency).
- States: BOOT=0, LOAD=1, RUN=2, HALT=3.
- BOOT: fs_o_ce=0. Counter increments each cycle; at count BOOT_DELAY-1, go to LOAD. All inputs are ignored.
- LOAD (one cycle): fs_o_change_pc=1, fs_o_pc=RESET_PC, fs_o_ce=1. Next state is RUN.
- RUN, per-cycle priority, highest first:
  1. ex_redirect: change_pc=1, pc=ex_target, flush_ifid=1, flush_idex=1, ce=1.
  2. id_redirect: change_pc=1, pc=id_target, flush_ifid=1, flush_idex=0, ce=1.
  3. halt: ce=0, next state HALT.
  4. stall: ce=0, change_pc=0, pc held.
  5. otherwise: ce=1, change_pc=0.
- Simultaneous ex_redirect and id_redirect: EX wins and the ID request is discarded (it belongs to a wrong-path instruction).
- A redirect overrides stall and halt in the same cycle. Stall and halt are levels, so they take effect on the following cycle if still asserted.
- Target bits [1:0] are forced to 0 on fs_o_pc (word alignment). No other arithmetic is applied.
- change_pc, flush_ifid and flush_idex are single-cycle pulses. They return to 0 on the next cycle unless a new redirect is sampled, so back-to-back redirects give back-to-back pulses.
- HALT: ce=0, change_pc=0, flushes=0. Redirect, stall and halt inputs are ignored. Exit is by reset only.
- Reset asserted mid-operation: immediate return to BOOT with outputs cleared, independent of the clock.
- fs_o_state reflects the registered state encoding above.

Optional Feature:
FETCH_PERF_CNT_EN. When defined, adds three outputs, each CNT_WIDTH wide:
- fs_o_redirect_cnt: counts cycles with change_pc=1 in RUN.
- fs_o_stall_cnt: counts RUN cycles where ce=0 because of stall.
- fs_o_flush_cnt: counts flush_ifid pulses.
Counter behaviour:
- Reset to 0.
- Saturate at all-ones; no wrap.
- Frozen in HALT.
When undefined, the ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Boot: release reset at t0 with BOOT_DELAY=2 -> ce=0 for 2 cycles; then one cycle with change_pc=1, pc=0x00000000, ce=1; then RUN with ce=1, change_pc=0.
- Stall: in RUN, hold stall for 3 cycles -> ce=0 for exactly 3 cycles (1 cycle delayed), pc held, then ce=1.
- Redirect priority: ex_redirect (target 0x40) and id_redirect (target 0x80) in the same cycle -> next cycle pc=0x40, change_pc=1, flush_ifid=1, flush_idex=1; 0x80 never appears.
- ID jump under stall: stall=1 and id_redirect with target 0x1E -> pc=0x1C (aligned), change_pc=1, ce=1, flush_ifid=1, flush_idex=0.
- Halt: assert halt in RUN -> ce=0 and state=3 next cycle. Subsequent ex_redirect produces no change_pc. Pulse reset low mid-cycle -> outputs are 0 immediately and state=0.
- FETCH_PERF_CNT_EN with CNT_WIDTH=2: 5 redirects -> fs_o_redirect_cnt=3 (saturated). Build without the macro -> the bench compiles without these ports.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: boot delay, reset-PC load, redirect/stall/halt arbitration and pipeline flushes.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer #(
    parameter int unsigned          PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned          BOOT_DELAY = 2,
    parameter int unsigned          CNT_WIDTH  = 16
) (
    input  logic                fs_clk,
    input  logic                fs_rst,
    input  logic                fs_i_stall,
    input  logic                fs_i_id_redirect,
    input  logic [PC_WIDTH-1:0] fs_i_id_target,
    input  logic                fs_i_ex_redirect,
    input  logic [PC_WIDTH-1:0] fs_i_ex_target,
    input  logic                fs_i_halt,
    output logic                fs_o_ce,
    output logic                fs_o_change_pc,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic                fs_o_flush_ifid,
    output logic                fs_o_flush_idex,
    output logic [1:0]          fs_o_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] fs_o_redirect_cnt,
    output logic [CNT_WIDTH-1:0] fs_o_stall_cnt,
    output logic [CNT_WIDTH-1:0] fs_o_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam logic [3:0]          BOOT_LAST  = 4'(BOOT_DELAY - 1);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    state_e                state_q,      state_d;
    logic [3:0]            boot_cnt_q,   boot_cnt_d;
    logic                  ce_q,         ce_d;
    logic                  change_pc_q,  change_pc_d;
    logic [PC_WIDTH-1:0]   pc_q,         pc_d;
    logic                  flush_ifid_q, flush_ifid_d;
    logic                  flush_idex_q, flush_idex_d;

    // Events used by the optional counters; always computed so both builds share one decode.
    logic run_redirect;
    logic run_stall;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q,    stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q,    flush_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
`endif

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        ce_d         = 1'b0;
        change_pc_d  = 1'b0;
        pc_d         = pc_q;
        flush_ifid_d = 1'b0;
        flush_idex_d = 1'b0;
        run_redirect = 1'b0;
        run_stall    = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d     = ST_LOAD;
                    ce_d        = 1'b1;
                    change_pc_d = 1'b1;
                    pc_d        = RESET_PC;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                ce_d    = 1'b1;
            end
            ST_RUN: begin
                // EX redirect wins: a simultaneous ID jump belongs to a wrong-path instruction.
                if (fs_i_ex_redirect) begin
                    ce_d         = 1'b1;
                    change_pc_d  = 1'b1;
                    pc_d         = fs_i_ex_target & ALIGN_MASK;
                    flush_ifid_d = 1'b1;
                    flush_idex_d = 1'b1;
                    run_redirect = 1'b1;
                end else if (fs_i_id_redirect) begin
                    ce_d         = 1'b1;
                    change_pc_d  = 1'b1;
                    pc_d         = fs_i_id_target & ALIGN_MASK;
                    flush_ifid_d = 1'b1;
                    run_redirect = 1'b1;
                end else if (fs_i_halt) begin
                    state_d = ST_HALT;
                end else if (fs_i_stall) begin
                    run_stall = 1'b1;
                end else begin
                    ce_d = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    // Counters freeze in HALT naturally: no RUN events are decoded there.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        if (run_redirect) begin
            redirect_cnt_d = sat_inc(redirect_cnt_q);
            flush_cnt_d    = sat_inc(flush_cnt_q);
        end
        if (run_stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            state_q        <= ST_BOOT;
            boot_cnt_q     <= '0;
            ce_q           <= 1'b0;
            change_pc_q    <= 1'b0;
            pc_q           <= RESET_PC;
            flush_ifid_q   <= 1'b0;
            flush_idex_q   <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            boot_cnt_q     <= boot_cnt_d;
            ce_q           <= ce_d;
            change_pc_q    <= change_pc_d;
            pc_q           <= pc_d;
            flush_ifid_q   <= flush_ifid_d;
            flush_idex_q   <= flush_idex_d;
`ifdef FETCH_PERF_CNT_EN
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
`endif
        end
    end

    assign fs_o_ce         = ce_q;
    assign fs_o_change_pc  = change_pc_q;
    assign fs_o_pc         = pc_q;
    assign fs_o_flush_ifid = flush_ifid_q;
    assign fs_o_flush_idex = flush_idex_q;
    assign fs_o_state      = state_q;

`ifdef FETCH_PERF_CNT_EN
    assign fs_o_redirect_cnt = redirect_cnt_q;
    assign fs_o_stall_cnt    = stall_cnt_q;
    assign fs_o_flush_cnt    = flush_cnt_q;
`endif

endmodule
